// File: rtl/whack_game_core.sv
// -----------------------------------------------------------------------------
// whack_game_core
//
// Game controller for a touch-screen whack-a-mole. It tracks the game state
// (IDLE/PLAY/PAUSE/OVER), maps a new touch onto a hole of the grid, and sends
// kill pulses back to the mole spawner for every slot whose mole sits in the
// touched hole. It also keeps score, combo, level, elapsed seconds and the
// high score.
//
// Ports
//   clk, rst       rising-edge clock, synchronous active-high reset
//   start, pause   one-cycle pulses: begin/restart game, toggle PLAY/PAUSE
//   tp_valid       touch pressed (level); a new press is its rising edge
//   tp_x, tp_y     touch coordinates in pixels
//   moles          hole index per spawner slot, all-ones = empty slot
//   survival       one-cycle pulse: a mole escaped
//   kill_list      one-cycle per-slot kill pulses to the spawner
//   mole_run       spawner enable, high only while playing
//   life_span      mole lifetime in cycles for the current level
//   score, high_score, kill, runaway, combo, level, timer  game counters
//   state          IDLE=0, PLAY=1, PAUSE=2, OVER=3
//   game_over      high while in OVER
// -----------------------------------------------------------------------------
module whack_game_core #(
  parameter int N_SLOTS         = 5,
  parameter int IDX_W           = 4,
  parameter int GRID_COLS       = 3,
  parameter int GRID_ROWS       = 3,
  parameter int GRID_X0         = 100,
  parameter int GRID_Y0         = 50,
  parameter int CELL_W          = 200,
  parameter int CELL_H          = 150,
  parameter int KILLS_PER_LEVEL = 9,
  parameter int MAX_LEVEL       = 4,
  parameter int MAX_RUNAWAY     = 10,
  parameter int COMBO_CAP       = 5,
  parameter int CLK_HZ          = 50_000_000,
  parameter int LIFE_BASE       = 50_000_000,
  parameter int LIFE_STEP       = 10_000_000,
  parameter int LIFE_MIN        = 10_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     tp_valid,
  input  logic [15:0]              tp_x,
  input  logic [15:0]              tp_y,
  input  logic [N_SLOTS*IDX_W-1:0] moles,
  input  logic                     survival,
  output logic [N_SLOTS-1:0]       kill_list,
  output logic                     mole_run,
  output logic [31:0]              life_span,
  output logic [15:0]              score,
  output logic [15:0]              high_score,
  output logic [7:0]               kill,
  output logic [7:0]               runaway,
  output logic [7:0]               combo,
  output logic [3:0]               level,
  output logic [9:0]               timer,
  output logic [1:0]               state,
  output logic                     game_over
);

  localparam int                 N_HOLES    = GRID_COLS * GRID_ROWS;
  localparam logic [IDX_W-1:0]   HOLES_W    = IDX_W'(N_HOLES);
  localparam logic [8:0]         TOTAL_W    = 9'(MAX_LEVEL * KILLS_PER_LEVEL);
  localparam logic [7:0]         RUN_LIM    = 8'(MAX_RUNAWAY);
  localparam logic [7:0]         CAP_W      = 8'(COMBO_CAP);
  localparam logic [3:0]         MAX_LVL    = 4'(MAX_LEVEL);
  localparam logic [31:0]        PRESC_LAST = 32'(CLK_HZ - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic                 tp_prev;
  logic [N_SLOTS-1:0]   kill_q;
  logic [31:0]          presc;

  logic [31:0]          tx, ty;
  int                   hit_c, hit_r;
  logic                 col_ok, row_ok, hit_ok;
  logic [IDX_W-1:0]     hit_hole;
  logic [N_SLOTS-1:0]   match;
  logic [8:0]           resolved;
  logic                 over_cond, start_game, playing;
  logic [15:0]          lvl_thresh, bonus;
  logic [7:0]           combo_capped;
  logic [16:0]          score_sum;
  logic [31:0]          life_dec;

  // ---------------------------------------------------------------------------
  // Touch -> hole mapping. Border pixels belong to no cell.
  // ---------------------------------------------------------------------------
  assign tx = 32'(tp_x);
  assign ty = 32'(tp_y);

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    hit_c  = 0;
    hit_r  = 0;
    col_ok = 1'b0;
    row_ok = 1'b0;
    for (int c = 0; c < GRID_COLS; c++) begin
      if (tx > 32'(GRID_X0 + c * CELL_W) && tx < 32'(GRID_X0 + (c + 1) * CELL_W)) begin
        col_ok = 1'b1;
        hit_c  = c;
      end
    end
    for (int r = 0; r < GRID_ROWS; r++) begin
      if (ty > 32'(GRID_Y0 + r * CELL_H) && ty < 32'(GRID_Y0 + (r + 1) * CELL_H)) begin
        row_ok = 1'b1;
        hit_r  = r;
      end
    end
    hit_ok   = col_ok && row_ok;
    hit_hole = IDX_W'(hit_r * GRID_COLS + hit_c);
  end

  // Empty slots (all-ones) and out-of-range indices never match.
  always_comb begin
    match = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      match[i] = hit_ok && (moles[i*IDX_W +: IDX_W] == hit_hole)
                        && (moles[i*IDX_W +: IDX_W] < HOLES_W);
    end
  end

  // ---------------------------------------------------------------------------
  // Game-level conditions
  // ---------------------------------------------------------------------------
  assign resolved   = {1'b0, kill} + {1'b0, runaway};
  assign over_cond  = (runaway >= RUN_LIM) || (resolved >= TOTAL_W);
  assign start_game = start && (state_q == S_IDLE || state_q == S_OVER);
  // The game-ending cycle updates nothing but the high score, so the score
  // copied into high_score is the final one.
  assign playing    = (state_q == S_PLAY) && !over_cond;

  assign lvl_thresh   = 16'(level) * 16'(KILLS_PER_LEVEL);
  assign combo_capped = (combo < CAP_W) ? combo : CAP_W;
  assign bonus        = 16'(level) + 16'(combo_capped);
  assign score_sum    = {1'b0, score} + {1'b0, bonus};

  // Lifetime shrinks by LIFE_STEP per level down to LIFE_MIN; written to avoid
  // unsigned underflow when the step would pass below the floor.
  always_comb begin
    life_dec = 32'(level - 4'd1) * 32'(LIFE_STEP);
    if (life_dec + 32'(LIFE_MIN) >= 32'(LIFE_BASE)) life_span = 32'(LIFE_MIN);
    else                                            life_span = 32'(LIFE_BASE) - life_dec;
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_OVER: if (start) state_d = S_PLAY;
      S_PLAY: begin
        if (over_cond)  state_d = S_OVER;
        else if (pause) state_d = S_PAUSE;
      end
      S_PAUSE:        if (pause) state_d = S_PLAY;
      default:        state_d = S_IDLE;
    endcase
  end

  assign state     = state_q;
  assign game_over = (state_q == S_OVER);
  assign mole_run  = (state_q == S_PLAY);
  assign kill_list = kill_q & {N_SLOTS{mole_run}};

  // ---------------------------------------------------------------------------
  // Counters and touch pipeline
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tp_prev    <= 1'b0;
      kill_q     <= '0;
      presc      <= '0;
      score      <= '0;
      high_score <= '0;
      kill       <= '0;
      runaway    <= '0;
      combo      <= '0;
      level      <= 4'd1;
      timer      <= '0;
    end else begin
      tp_prev <= tp_valid;
      kill_q  <= (playing && tp_valid && !tp_prev) ? match : '0;

      if (start_game) begin
        presc   <= '0;
        score   <= '0;
        kill    <= '0;
        runaway <= '0;
        combo   <= '0;
        level   <= 4'd1;
        timer   <= '0;
      end else if (state_q == S_PLAY && over_cond) begin
        if (score > high_score) high_score <= score;
      end else if (playing) begin
        // One kill per cycle no matter how many slots were hit.
        if (|kill_list) begin
          kill  <= (kill == '1) ? kill : kill + 8'd1;
          score <= score_sum[16] ? '1 : score_sum[15:0];
        end
        if (survival) begin
          runaway <= (runaway == '1) ? runaway : runaway + 8'd1;
          combo   <= '0;
        end else if (|kill_list) begin
          combo   <= (combo == '1) ? combo : combo + 8'd1;
        end
        if (16'(resolved) >= lvl_thresh && level < MAX_LVL) level <= level + 4'd1;
        if (presc == PRESC_LAST) begin
          presc <= '0;
          timer <= (timer == '1) ? timer : timer + 10'd1;
        end else begin
          presc <= presc + 32'd1;
        end
      end
    end
  end

endmodule
